// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int LATENCY_MAX    = 15;
  localparam int CNT_W          = 4;
  localparam int DEFAULT_DEPTH  = 256;
  localparam int DEFAULT_ADDR_W = 8;
  localparam int REG_IDX_W      = 5;

endpackage

// File: rtl/data_mem.sv
// Private data memory: DEPTH x 32, synchronous write, combinational read.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: multi-cycle load/store to a private memory with a
// registered valid/ready result toward write-back.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds valid and its payload stable until then.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          alu_result,
  input  logic [31:0]          st_val,
  input  logic                 mem_read_en,
  input  logic                 mem_write_en,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] dest,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic                 out_wb_en,
  output logic [REG_IDX_W-1:0] out_dest,
  output logic                 addr_err
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          addr_word_q, addr_word_d;
  logic [31:0]          st_val_q, st_val_d;
  logic [REG_IDX_W-1:0] dest_q, dest_d;
  logic                 wb_en_q, wb_en_d;
  logic                 store_q, store_d;
  logic                 oob_q, oob_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_data_q, out_data_d;
  logic                 out_wb_en_q, out_wb_en_d;
  logic [REG_IDX_W-1:0] out_dest_q, out_dest_d;
  logic                 addr_err_q, addr_err_d;

  logic        accept;
  logic        in_oob;
  logic        last_cycle;
  logic        mem_we;
  logic [31:0] mem_rdata;

  assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign in_oob     = |alu_result[31:ADDR_W];
  assign last_cycle = (state_q == ACCESS) && (cnt_q == '0);
  // Out-of-range stores are suppressed; a read+write is a store.
  assign mem_we     = last_cycle && store_q && !oob_q;

  data_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_word_q[ADDR_W-1:0]),
    .wdata (st_val_q),
    .rdata (mem_rdata)
  );

  // Next-state logic for the FSM, operand latches and output register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_word_d = addr_word_q;
    st_val_d    = st_val_q;
    dest_d      = dest_q;
    wb_en_d     = wb_en_q;
    store_d     = store_q;
    oob_d       = oob_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_wb_en_d = out_wb_en_q;
    out_dest_d  = out_dest_q;
    addr_err_d  = addr_err_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mem_read_en || mem_write_en) begin
            state_d     = ACCESS;
            cnt_d       = CNT_INIT;
            addr_word_d = alu_result;
            st_val_d    = st_val;
            dest_d      = dest;
            wb_en_d     = wb_en;
            store_d     = mem_write_en;
            oob_d       = in_oob;
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = alu_result;
            out_wb_en_d = wb_en;
            out_dest_d  = dest;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          out_dest_d  = dest_q;
          if (store_q) begin
            out_data_d  = addr_word_q;
            out_wb_en_d = 1'b0;
          end else begin
            out_data_d  = oob_q ? 32'h0 : mem_rdata;
            out_wb_en_d = wb_en_q;
          end
          if (oob_q) addr_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_word_q <= '0;
      st_val_q    <= '0;
      dest_q      <= '0;
      wb_en_q     <= 1'b0;
      store_q     <= 1'b0;
      oob_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_wb_en_q <= 1'b0;
      out_dest_q  <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_word_q <= addr_word_d;
      st_val_q    <= st_val_d;
      dest_q      <= dest_d;
      wb_en_q     <= wb_en_d;
      store_q     <= store_d;
      oob_q       <= oob_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_wb_en_q <= out_wb_en_d;
      out_dest_q  <= out_dest_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_wb_en = out_wb_en_q;
  assign out_dest  = out_dest_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized ops checked
// against a transaction-level memory model.
module tb_mem_stage;

  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_valid1;
  logic [31:0] alu_result, st_val;
  logic        mem_read_en, mem_write_en, wb_en, out_ready;
  logic [4:0]  dest;

  logic        in_ready, out_valid, out_wb_en, addr_err;
  logic [31:0] out_data;
  logic [4:0]  out_dest;

  logic        in_ready1, out_valid1, out_wb_en1, addr_err1;
  logic [31:0] out_data1;
  logic [4:0]  out_dest1;

  mem_stage #(.DEPTH(256), .ADDR_W(8), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .st_val(st_val), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .wb_en(wb_en), .dest(dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_wb_en(out_wb_en), .out_dest(out_dest), .addr_err(addr_err)
  );

  mem_stage #(.DEPTH(256), .ADDR_W(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .alu_result(alu_result), .st_val(st_val), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .wb_en(wb_en), .dest(dest),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_wb_en(out_wb_en1), .out_dest(out_dest1), .addr_err(addr_err1)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [256];
  bit          ref_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] alu, input logic [31:0] sv,
                       input logic rd, input logic wr, input logic wb,
                       input logic [4:0] dst);
    alu_result   = alu;
    st_val       = sv;
    mem_read_en  = rd;
    mem_write_en = wr;
    wb_en        = wb;
    dest         = dst;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_valid1    = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
  endtask

  // Issue one op to u_dut (out_ready assumed 1) and check its result
  // against the model: latency, busy cycles, data, wb_en, dest, addr_err.
  task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] sv,
                        input logic rd, input logic wr, input logic wb,
                        input logic [4:0] dst);
    logic [31:0] e_data;
    logic        e_wb;
    int          e_lat;
    int          n;
    bit          oob;
    logic [31:0] upper;
    upper = alu >> 8;
    oob   = (upper != 0);
    if (!rd && !wr) begin
      e_data = alu; e_wb = wb; e_lat = 0;
    end else begin
      e_lat = LAT;
      if (oob) ref_err = 1'b1;
      if (wr) begin
        if (!oob) ref_mem[alu % 256] = sv;
        e_data = alu; e_wb = 1'b0;
      end else begin
        e_data = oob ? 32'h0 : ref_mem[alu % 256];
        e_wb   = wb;
      end
    end
    exp_q.push_back(e_data);

    @(negedge clk);
    drive(alu, sv, rd, wr, wb, dst);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_ready_to"}, 32'(n < 50), 32'd1);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 50) begin
      check({tag, "_busy"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"},   n, e_lat);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  out_data, exp_q.pop_front());
    check({tag, "_wb"},    32'(out_wb_en), 32'(e_wb));
    check({tag, "_dest"},  32'(out_dest), 32'(dst));
    check({tag, "_err"},   32'(addr_err), 32'(ref_err));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] held;
    int kind;
    int a;
    rst_n = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    ref_err = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  out_data, 32'd0);
    check("rst_wb",    32'(out_wb_en), 32'd0);
    check("rst_dest",  32'(out_dest), 32'd0);
    check("rst_err",   32'(addr_err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // known content at word 5, then a store aborted by reset mid-access
    run_op("st5", 32'd5, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 5'd1);
    @(negedge clk);
    drive(32'd5, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 5'd2);
    in_valid = 1'b1;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("abort_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_data",  out_data, 32'd0);
    check("abort_wb",    32'(out_wb_en), 32'd0);
    check("abort_dest",  32'(out_dest), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    ref_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("ld5", 32'd5, 32'h0, 1'b1, 1'b0, 1'b1, 5'd6);

    // pass-through and back-to-back stream
    run_op("alu", 32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(32'h1000 + i, 32'h0, 1'b0, 1'b0, 1'b1, 5'(i + 1));
      in_valid = 1'b1;
      @(negedge clk);
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data",  out_data, 32'h1000 + i);
      check("stream_dest",  32'(out_dest), 32'(i + 1));
    end
    idle_inputs();

    // store/load round trip
    run_op("st10", 32'd10, 32'hCAFE_0001, 1'b0, 1'b1, 1'b1, 5'd2);
    run_op("ld10", 32'd10, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7);

    // back-pressure: result held while out_ready is low
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'hABCD, 32'h0, 1'b0, 1'b0, 1'b1, 5'd12);
    in_valid = 1'b1;
    @(posedge clk);
    #1 idle_inputs();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data",  out_data, 32'hABCD);
      check("bp_dest",  32'(out_dest), 32'd12);
    end
    out_ready = 1'b1;
    drive(32'h7777, 32'h0, 1'b0, 1'b0, 1'b0, 5'd13);
    in_valid = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_data", out_data, 32'h7777);
    check("bp_next_wb",   32'(out_wb_en), 32'd0);

    // address error: out-of-range load, then store must not alias word 0
    run_op("st0",    32'd0, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 5'd1);
    run_op("ld_oob", 32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4);
    run_op("st_oob", 32'h0000_0100, 32'h1357_9BDF, 1'b0, 1'b1, 1'b0, 5'd4);
    run_op("ld0",    32'd0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5);

    // read+write together behaves as a store
    run_op("rw3", 32'd3, 32'h55, 1'b1, 1'b1, 1'b1, 5'd8);
    run_op("ld3", 32'd3, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9);

    // same corner on the LATENCY=1 instance
    @(negedge clk);
    drive(32'd3, 32'h55, 1'b1, 1'b1, 1'b1, 5'd9);
    in_valid1 = 1'b1;
    check("l1_ready", 32'(in_ready1), 32'd1);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("l1_busy",  32'(in_ready1), 32'd0);
    check("l1_early", 32'(out_valid1), 32'd0);
    @(negedge clk);
    check("l1_valid", 32'(out_valid1), 32'd1);
    check("l1_data",  out_data1, 32'd3);
    check("l1_wb",    32'(out_wb_en1), 32'd0);
    check("l1_dest",  32'(out_dest1), 32'd9);
    drive(32'd3, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4);
    in_valid1 = 1'b1;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("l1_ld_early", 32'(out_valid1), 32'd0);
    @(negedge clk);
    check("l1_ld_valid", 32'(out_valid1), 32'd1);
    check("l1_ld_data",  out_data1, 32'h55);
    check("l1_ld_wb",    32'(out_wb_en1), 32'd1);
    check("l1_ld_dest",  32'(out_dest1), 32'd4);

    // randomized traffic over words 16..31 (all written first)
    for (int i = 16; i < 32; i++)
      run_op("rinit", 32'(i), $urandom, 1'b0, 1'b1, 1'b0, 5'($urandom_range(0, 31)));
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      a    = $urandom_range(16, 31);
      if (kind < 3)
        run_op("rnd_alu", $urandom, 32'h0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)));
      else if (kind < 6)
        run_op("rnd_st", 32'(a), $urandom, 1'b0, 1'b1, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)));
      else if (kind < 9)
        run_op("rnd_ld", 32'(a), 32'h0, 1'b1, 1'b0, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)));
      else begin
        held = 32'($urandom_range(1, 255)) << 8;
        run_op("rnd_oob", held | 32'(a), $urandom, 1'b1, 1'($urandom_range(0, 1)), 1'b1,
               5'($urandom_range(0, 31)));
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
